// File: rtl/io_bridge.sv
// io_bridge
//   Memory-mapped I/O bridge between the processor memory port and a
//   2^RAM_AW-word data RAM. Decodes the address, steers stores to the RAM or
//   to the peripheral registers (LED, HEX, TIMER, STATUS), and returns load
//   data on DIN one edge after the address is presented.
//
// Ports
//   Clock              : single clock, rising edge
//   Resetn             : asynchronous reset, active HIGH despite the name
//   Adress_in[15:0]    : processor address
//   DOUT[15:0]         : processor store data
//   Enable_escrita_mem : store strobe, qualifies Adress_in/DOUT this cycle
//   SW[15:0]           : raw asynchronous switch inputs
//   ram_rdata[15:0]    : RAM read data (one-cycle synchronous read)
//   ram_addr           : RAM address, combinational
//   ram_wdata[15:0]    : RAM write data, combinational
//   ram_wren           : RAM write enable, combinational
//   DIN[15:0]          : load data to the processor
//   LED[15:0]          : LED register
//   HEX[15:0]          : HEX register
//   timer_expired      : sticky timer expiry flag
module io_bridge #(
   parameter int unsigned RAM_AW    = 5,
   parameter int unsigned TIMER_DIV = 50000
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [15:0]       Adress_in,
   input  logic [15:0]       DOUT,
   input  logic              Enable_escrita_mem,
   input  logic [15:0]       SW,
   input  logic [15:0]       ram_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              ram_wren,
   output logic [15:0]       DIN,
   output logic [15:0]       LED,
   output logic [15:0]       HEX,
   output logic              timer_expired
);

   localparam int unsigned PW = $clog2(TIMER_DIV);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_HEX,
      SEL_SW,
      SEL_TIMER,
      SEL_STATUS
   } sel_t;

   sel_t          sel_d;
   sel_t          sel_q;
   logic [15:0]   periph_d;
   logic [15:0]   periph_q;
   logic [15:0]   sw_meta;
   logic [15:0]   sw_sync;
   logic [15:0]   timer_q;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic          wr_led;
   logic          wr_hex;
   logic          wr_timer;
   logic          wr_status;
   logic          expire;

   // ---------------------------------------------------------------- decode
   always_comb begin
      sel_d = SEL_NONE;
      if ((Adress_in >> RAM_AW) == '0) begin
         sel_d = SEL_RAM;
      end else if (Adress_in[15:8] == 8'h00) begin
         case (Adress_in[7:0])
            8'h80:   sel_d = SEL_LED;
            8'h81:   sel_d = SEL_HEX;
            8'h82:   sel_d = SEL_SW;
            8'h83:   sel_d = SEL_TIMER;
            8'h84:   sel_d = SEL_STATUS;
            default: sel_d = SEL_NONE;
         endcase
      end
   end

   assign ram_addr  = Adress_in[RAM_AW-1:0];
   assign ram_wdata = DOUT;
   assign ram_wren  = Enable_escrita_mem && (sel_d == SEL_RAM);

   assign wr_led    = Enable_escrita_mem && (sel_d == SEL_LED);
   assign wr_hex    = Enable_escrita_mem && (sel_d == SEL_HEX);
   assign wr_timer  = Enable_escrita_mem && (sel_d == SEL_TIMER);
   assign wr_status = Enable_escrita_mem && (sel_d == SEL_STATUS);

   // ------------------------------------------------------------- registers
   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) begin
         LED <= '0;
         HEX <= '0;
      end else begin
         if (wr_led) LED <= DOUT;
         if (wr_hex) HEX <= DOUT;
      end
   end

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= SW;
         sw_sync <= sw_meta;
      end
   end

   // ----------------------------------------------------------------- timer
   assign tick = (presc_q == PW'(TIMER_DIV - 1));

   // A TIMER write takes priority over a coincident tick, so expiry can only
   // come from a real 1 -> 0 decrement, never from loading zero.
   assign expire = tick && !wr_timer && (timer_q == 16'd1);

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) begin
         presc_q <= '0;
         timer_q <= '0;
      end else if (wr_timer) begin
         presc_q <= '0;
         timer_q <= DOUT;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick && (timer_q != '0)) timer_q <= timer_q - 1'b1;
      end
   end

   // Set beats clear when both land on the same edge.
   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn)         timer_expired <= 1'b0;
      else if (expire)    timer_expired <= 1'b1;
      else if (wr_status) timer_expired <= 1'b0;
   end

   // ------------------------------------------------------------- load path
   always_comb begin
      periph_d = '0;
      case (sel_d)
         SEL_LED:    periph_d = LED;
         SEL_HEX:    periph_d = HEX;
         SEL_SW:     periph_d = sw_sync;
         SEL_TIMER:  periph_d = timer_q;
         SEL_STATUS: periph_d = {15'b0, timer_expired};
         default:    periph_d = '0;
      endcase
   end

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) begin
         sel_q    <= SEL_NONE;
         periph_q <= '0;
      end else begin
         sel_q    <= sel_d;
         periph_q <= periph_d;
      end
   end

   // RAM data arrives one cycle after the address, aligned with sel_q.
   assign DIN = (sel_q == SEL_RAM) ? ram_rdata : periph_q;

endmodule
